// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the switch/button conditioning front end:
// power-up sequencer state encodings and the default debounce interval.
package switch_conditioner_pkg;

  // Power-up sequencer states (2-bit encoding, reused by other front ends)
  typedef enum logic [1:0] {
    PWR_IDLE  = 2'd0,
    PWR_COUNT = 2'd1,
    PWR_FIRE  = 2'd2,
    PWR_DONE  = 2'd3
  } pwr_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/switch_debounce_ch.sv
// One input channel: multi-flop synchroniser, persistence-count debouncer
// and registered rise/fall pulses on each accepted level change.
module switch_debounce_ch
  import switch_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic INIT_VAL        = 1'b0,
  localparam int  CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic RESET,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain shift-register synchroniser; nothing between the stages
  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_q <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // Accept a new level only after it has persisted DEBOUNCE_CYCLES samples;
  // any return to the current level restarts the count from zero
  always_ff @(posedge clk) begin
    if (RESET) begin
      level <= INIT_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// N-channel switch/button front end: per-channel sync + debounce + edges,
// a one-shot power-up pulse after a sustained clock lock, and a registered
// "something changed" strobe for downstream controllers.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int   NUM_CH          = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic INIT_VAL        = 1'b0,
  parameter int   PWRUP_CYCLES    = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] async_in,
  input  logic              lock,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              pwrup,
  output logic              any_change
);

  localparam int PCNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PWRUP_CYCLES - 1);

  // Sequencer state is kept as a named typed register so checkers can bind to it
  pwr_state_t        pwr_state;
  logic [PCNT_W-1:0] pcnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    switch_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_VAL       (INIT_VAL)
    ) u_ch (
      .clk     (clk),
      .RESET   (RESET),
      .async_in(async_in[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // Power-up sequencer: count consecutive lock-high cycles, pulse once, then
  // stay done until reset (the IDLE->COUNT step counts as the first lock cycle)
  always_ff @(posedge clk) begin
    if (RESET) begin
      pwr_state <= PWR_IDLE;
      pcnt      <= '0;
      pwrup     <= 1'b0;
    end else begin
      pwrup <= 1'b0;
      case (pwr_state)
        PWR_IDLE: begin
          if (lock) begin
            if (PWRUP_CYCLES == 1) begin
              pwr_state <= PWR_FIRE;
              pwrup     <= 1'b1;
            end else begin
              pwr_state <= PWR_COUNT;
              pcnt      <= PCNT_W'(1);
            end
          end
        end
        PWR_COUNT: begin
          if (!lock) begin
            pwr_state <= PWR_IDLE;
            pcnt      <= '0;
          end else if (pcnt == PCNT_LAST) begin
            pwr_state <= PWR_FIRE;
            pwrup     <= 1'b1;
            pcnt      <= '0;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        PWR_FIRE: pwr_state <= PWR_DONE;
        PWR_DONE: pwr_state <= PWR_DONE;
        default:  pwr_state <= PWR_IDLE;
      endcase
    end
  end

  // One strobe per cycle in which any edge or the power-up pulse occurred
  always_ff @(posedge clk) begin
    if (RESET) begin
      any_change <= 1'b0;
    end else begin
      any_change <= (|rise) | (|fall) | pwrup;
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with a short debounce interval.
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_switch_conditioner;

  localparam int W = 14;  // {level[3:0], rise[3:0], fall[3:0], pwrup, any_change}

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] async_in = 4'h0;
  logic       lock = 1'b0;
  logic [3:0] level, rise, fall;
  logic       pwrup, any_change;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic [3:0]   a;
    logic         lk;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  switch_conditioner #(
    .NUM_CH         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .INIT_VAL       (1'b0),
    .PWRUP_CYCLES   (4)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .async_in  (async_in),
    .lock      (lock),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .pwrup     (pwrup),
    .any_change(any_change)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [3:0] lv, input logic [3:0] rs,
                                        input logic [3:0] fl, input logic pw, input logic ac);
    return {lv, rs, fl, pw, ac};
  endfunction

  // Drive one cycle of inputs, queue its expectation, then compare after the edge
  task automatic tick(input logic rst, input logic [3:0] a, input logic lk,
                      input logic [W-1:0] exp, input string name);
    logic [W-1:0] got;
    logic [W-1:0] e;
    RESET    = rst;
    async_in = a;
    lock     = lk;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    got = {level, rise, fall, pwrup, any_change};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got lv=%h r=%h f=%h p=%b ac=%b, expected lv=%h r=%h f=%h p=%b ac=%b",
               name, got[13:10], got[9:6], got[5:2], got[1], got[0],
               e[13:10], e[9:6], e[5:2], e[1], e[0]);
    end
  endtask

  initial begin
    logic [3:0] lv, rs, fl;
    logic       pw, ac;
    logic [8:0] lk_seq;

    // Reset with all pins high, then a short pin glitch right after release
    vecs[0] = '{1'b1, 4'hF, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[1] = '{1'b1, 4'hF, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[2] = '{1'b1, 4'hF, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[3] = '{1'b0, 4'hF, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[4] = '{1'b0, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[5] = '{1'b0, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[6] = '{1'b0, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};
    vecs[7] = '{1'b0, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0)};

    @(negedge clk);
    for (int i = 0; i < 8; i++)
      tick(vecs[i].rst, vecs[i].a, vecs[i].lk, vecs[i].exp, $sformatf("reset_vec[%0d]", i));

    // Clean edge on channel 1: accepted at edge 9, strobe at edge 10
    for (int k = 0; k < 12; k++) begin
      lv = (k >= 9) ? 4'b0010 : 4'b0000;
      rs = (k == 9) ? 4'b0010 : 4'b0000;
      ac = (k == 10);
      tick(1'b0, 4'b0010, 1'b0, pack(lv, rs, 4'h0, 1'b0, ac), $sformatf("clean_edge[%0d]", k));
    end

    // Short glitch on channel 2 (5 cycles) must be rejected
    for (int k = 0; k < 17; k++)
      tick(1'b0, (k < 5) ? 4'b0110 : 4'b0010, 1'b0, pack(4'b0010, 4'h0, 4'h0, 1'b0, 1'b0),
           $sformatf("short_glitch[%0d]", k));

    // Glitch of exactly 8 cycles: accepted at edge 9, then falls back at edge 17
    for (int k = 0; k < 20; k++) begin
      lv = 4'b0010 | ((k >= 9 && k < 17) ? 4'b0100 : 4'b0000);
      rs = (k == 9)  ? 4'b0100 : 4'b0000;
      fl = (k == 17) ? 4'b0100 : 4'b0000;
      ac = (k == 10) || (k == 18);
      tick(1'b0, (k < 8) ? 4'b0110 : 4'b0010, 1'b0, pack(lv, rs, fl, 1'b0, ac),
           $sformatf("exact_glitch[%0d]", k));
    end

    // Release channel 1 so every channel is low
    for (int k = 0; k < 12; k++) begin
      lv = (k >= 9) ? 4'b0000 : 4'b0010;
      fl = (k == 9) ? 4'b0010 : 4'b0000;
      ac = (k == 10);
      tick(1'b0, 4'h0, 1'b0, pack(lv, 4'h0, fl, 1'b0, ac), $sformatf("release_ch1[%0d]", k));
    end

    // All four channels rise together: one rise vector, one strobe
    for (int k = 0; k < 12; k++) begin
      lv = (k >= 9) ? 4'hF : 4'h0;
      rs = (k == 9) ? 4'hF : 4'h0;
      ac = (k == 10);
      tick(1'b0, 4'hF, 1'b0, pack(lv, rs, 4'h0, 1'b0, ac), $sformatf("simultaneous[%0d]", k));
    end

    // Fresh reset, then steady lock: pulse on the 4th lock cycle
    for (int k = 0; k < 2; k++)
      tick(1'b1, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), $sformatf("pwr_reset[%0d]", k));
    for (int k = 0; k < 8; k++) begin
      pw = (k == 3);
      ac = (k == 4);
      tick(1'b0, 4'h0, 1'b1, pack(4'h0, 4'h0, 4'h0, pw, ac), $sformatf("pwrup_steady[%0d]", k));
    end
    for (int k = 0; k < 8; k++)
      tick(1'b0, 4'h0, k[0], pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), $sformatf("pwrup_no_refire[%0d]", k));

    // Interrupted lock run: only the final uninterrupted run of 4 fires
    tick(1'b1, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), "pwr_reset2");
    lk_seq = 9'b111111011;  // applied LSB first: 1,1,0,1,1,1,1,1,1
    for (int k = 0; k < 9; k++) begin
      pw = (k == 6);
      ac = (k == 7);
      tick(1'b0, 4'h0, lk_seq[k], pack(4'h0, 4'h0, 4'h0, pw, ac), $sformatf("pwrup_interrupt[%0d]", k));
    end
    for (int k = 0; k < 6; k++)
      tick(1'b0, 4'h0, ~k[0], pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), $sformatf("pwrup_toggle[%0d]", k));

    // Reset while a change on channel 0 is one count from acceptance
    tick(1'b1, 4'h0, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), "mid_reset_pre");
    for (int k = 0; k < 8; k++)
      tick(1'b0, 4'b0001, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), $sformatf("mid_pending[%0d]", k));
    tick(1'b1, 4'b0001, 1'b0, pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0), "mid_reset_pulse");
    for (int k = 0; k < 12; k++) begin
      lv = (k >= 9) ? 4'b0001 : 4'b0000;
      rs = (k == 9) ? 4'b0001 : 4'b0000;
      ac = (k == 10);
      tick(1'b0, 4'b0001, 1'b0, pack(lv, rs, 4'h0, 1'b0, ac), $sformatf("mid_reaccept[%0d]", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
